// File: rtl/cmu_pkg.sv
// Shared address-field and encoding definitions for the cache management unit and its cache.
package cmu_pkg;

  localparam int unsigned AddrBits  = 32;
  localparam int unsigned TagBits   = 23;
  localparam int unsigned LineWords = 4;
  localparam int unsigned WordLsb   = 2;

  // u_b_h_w: bit 2 = zero-extend, bits 1:0 = 00 byte / 01 half / 10 word
  localparam logic [2:0] UbhwWord = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StPreBack,
    StBack,
    StFill,
    StWait
  } cmu_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cmu_if.sv
// Cache lookup/fill bus between the CMU (master) and the cache array (slave).
interface cmu_if #(
  parameter int unsigned ADDR_BITS = cmu_pkg::AddrBits,
  parameter int unsigned TAG_BITS  = cmu_pkg::TagBits
);
  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_load;
  logic                 cache_store;
  logic                 cache_edit;
  logic                 cache_invalid;
  logic [2:0]           cache_u_b_h_w;
  logic [31:0]          cache_din;
  logic                 cache_hit;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;
  logic [31:0]          cache_dout;

  modport master (
    output cache_addr, cache_load, cache_store, cache_edit, cache_invalid, cache_u_b_h_w,
           cache_din,
    input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout
  );

  modport slave (
    input  cache_addr, cache_load, cache_store, cache_edit, cache_invalid, cache_u_b_h_w,
           cache_din,
    output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout
  );
endinterface

// File: rtl/cmu.sv
// Cache management unit: serves CPU requests from the cache, writing back a dirty victim
// line and refilling from memory on a miss.
module cmu
  import cmu_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = AddrBits,
  parameter int unsigned TAG_BITS   = TagBits,
  parameter int unsigned LINE_WORDS = LineWords
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  cmu_if.master                cache_io,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int unsigned KBits    = $clog2(LINE_WORDS);
  localparam int unsigned IndexLsb = WordLsb + KBits;
  localparam int unsigned IndexMsb = ADDR_BITS - TAG_BITS - 1;
  localparam logic [KBits-1:0] KMax = KBits'(LINE_WORDS - 1);

  cmu_state_e state_q, state_d;
  logic [KBits-1:0]     k_q, k_d;
  logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [2:0]           req_ubhw_q, req_ubhw_d;
  logic [31:0]          req_data_q, req_data_d;
  logic                 req_wr_q, req_wr_d;
  logic                 retry_q, retry_d;
  logic [TAG_BITS-1:0]  victim_tag_q, victim_tag_d;
  logic [31:0]          data_r_q, data_r_d;
  logic [31:0]          hit_q, hit_d;
  logic [31:0]          miss_q, miss_d;

  logic                 req_valid;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [ADDR_BITS-1:0] fill_addr;

  assign req_valid = en_r | en_w;
  assign wb_addr   = {victim_tag_q, req_addr_q[IndexMsb:IndexLsb], k_q, 2'b00};
  assign fill_addr = {req_addr_q[ADDR_BITS-1 -: TAG_BITS], req_addr_q[IndexMsb:IndexLsb], k_q,
                      2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      req_addr_q   <= '0;
      req_ubhw_q   <= '0;
      req_data_q   <= '0;
      req_wr_q     <= 1'b0;
      retry_q      <= 1'b0;
      victim_tag_q <= '0;
      data_r_q     <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      req_addr_q   <= req_addr_d;
      req_ubhw_q   <= req_ubhw_d;
      req_data_q   <= req_data_d;
      req_wr_q     <= req_wr_d;
      retry_q      <= retry_d;
      victim_tag_q <= victim_tag_d;
      data_r_q     <= data_r_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    req_addr_d   = req_addr_q;
    req_ubhw_d   = req_ubhw_q;
    req_data_d   = req_data_q;
    req_wr_d     = req_wr_q;
    retry_d      = retry_q;
    victim_tag_d = victim_tag_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          req_addr_d = addr_rw;
          req_ubhw_d = u_b_h_w;
          req_data_d = data_w;
          req_wr_d   = en_w;
          retry_d    = 1'b0;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (cache_io.cache_hit) begin
          state_d = StIdle;
        end else begin
          k_d = '0;
          if (cache_io.cache_valid && cache_io.cache_dirty) begin
            victim_tag_d = cache_io.cache_tag;
            state_d      = StPreBack;
          end else begin
            state_d = StFill;
          end
        end
      end
      StPreBack: state_d = StBack;
      StBack: begin
        if (mem_ack_i) begin
          if (k_q == KMax) begin
            k_d     = '0;
            state_d = StFill;
          end else begin
            k_d     = k_q + KBits'(1);
            state_d = StPreBack;
          end
        end
      end
      StFill: begin
        if (mem_ack_i) begin
          k_d = k_q + KBits'(1);
          if (k_q == KMax) state_d = StWait;
        end
      end
      StWait: begin
        retry_d = 1'b1;
        state_d = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  // The re-lookup after a refill is bookkeeping only, so it is not counted.
  always_comb begin
    data_r_d = data_r_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (state_q == StLookup) begin
      if (cache_io.cache_hit && !req_wr_q) data_r_d = cache_io.cache_dout;
      if (!retry_q) begin
        if (cache_io.cache_hit) hit_d = sat_inc(hit_q);
        else                    miss_d = sat_inc(miss_q);
      end
    end
  end

  always_comb begin
    stall                  = 1'b0;
    cache_io.cache_addr    = '0;
    cache_io.cache_load    = 1'b0;
    cache_io.cache_store   = 1'b0;
    cache_io.cache_edit    = 1'b0;
    cache_io.cache_invalid = 1'b0;
    cache_io.cache_u_b_h_w = '0;
    cache_io.cache_din     = '0;
    mem_cs_o               = 1'b0;
    mem_we_o               = 1'b0;
    mem_addr_o             = '0;
    mem_data_o             = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          stall                  = 1'b1;
          cache_io.cache_addr    = addr_rw;
          cache_io.cache_load    = en_r & ~en_w;
          cache_io.cache_edit    = en_w;
          cache_io.cache_u_b_h_w = u_b_h_w;
          cache_io.cache_din     = data_w;
        end
      end
      StLookup: stall = ~cache_io.cache_hit;
      StPreBack: begin
        stall               = 1'b1;
        cache_io.cache_addr = wb_addr;
      end
      StBack: begin
        // Keep addressing the victim word so cache_dout stays put until the ack.
        stall               = 1'b1;
        cache_io.cache_addr = wb_addr;
        mem_cs_o            = 1'b1;
        mem_we_o            = 1'b1;
        mem_addr_o          = wb_addr;
        mem_data_o          = cache_io.cache_dout;
      end
      StFill: begin
        stall      = 1'b1;
        mem_cs_o   = 1'b1;
        mem_addr_o = fill_addr;
        if (mem_ack_i) begin
          cache_io.cache_store   = 1'b1;
          cache_io.cache_addr    = fill_addr;
          cache_io.cache_din     = mem_data_i;
          cache_io.cache_u_b_h_w = UbhwWord;
        end
      end
      StWait: begin
        stall                  = 1'b1;
        cache_io.cache_addr    = req_addr_q;
        cache_io.cache_load    = ~req_wr_q;
        cache_io.cache_edit    = req_wr_q;
        cache_io.cache_u_b_h_w = req_ubhw_q;
        cache_io.cache_din     = req_data_q;
      end
      default: stall = 1'b0;
    endcase
  end

  assign data_r   = data_r_q;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule
